// File: rtl/digit_receiver.sv
// digit_receiver
//   Receiving end of the 3-bit digit link. The data lines and the strobe are
//   asynchronous. They pass through 2-flop synchronizers and are then qualified
//   by a pulse-length FSM. The FSM captures one digit (0..6) for each
//   well-formed strobe pulse. It rejects the following pulses:
//     - too short: dropped silently as a glitch
//     - too long: stuck strobe, err is raised
//     - data changing while the strobe is high: err is raised
//     - code 7: err is raised
//
//   Optional feature, macro RX_FIFO_EN:
//     Undefined: valid is a one-cycle pulse per digit. num holds the last digit.
//                ready is ignored.
//     Defined:   a 4-entry FIFO sits in front of num/valid. num is the head and
//                valid means the FIFO is non-empty. Asserting ready pops the
//                head. A digit arriving when the FIFO is full is dropped and
//                raises err.
//
// Ports:
//   hwclk      system clock
//   rst_n      asynchronous active-low reset
//   in0..in2   data bits, asynchronous
//   controlIn  strobe, asynchronous
//   ready      consumer accepts the head digit (FIFO build only)
//   num        received digit
//   valid      num is valid
//   err        one-cycle pulse for each rejected pulse or dropped digit
//   busy       high whenever the receiver is not idle
module digit_receiver #(
    parameter int HOLD_TIME = 1200000,
    parameter int MIN_PULSE = HOLD_TIME / 2,
    parameter int MAX_PULSE = HOLD_TIME * 2,
    parameter int MIN_GAP   = HOLD_TIME / 2
) (
    input  logic       hwclk,
    input  logic       rst_n,
    input  logic       in0,
    input  logic       in1,
    input  logic       in2,
    input  logic       controlIn,
    input  logic       ready,
    output logic [2:0] num,
    output logic       valid,
    output logic       err,
    output logic       busy
);

    typedef enum logic [1:0] {IDLE, HIGH, STUCK, GAP} state_t;

    localparam logic [31:0] MIN_PULSE_C = 32'(MIN_PULSE);
    localparam logic [31:0] MAX_PULSE_C = 32'(MAX_PULSE);
    localparam logic [31:0] MIN_GAP_C   = 32'(MIN_GAP);

    // Bit 3 of each synchronizer stage is the strobe; bits 2:0 are the data.
    logic [3:0]  meta_q, meta_d, sync_q, sync_d;
    state_t      state_q, state_d;
    logic [31:0] cnt_q, cnt_d, cnt_inc;
    logic [2:0]  shadow_q, shadow_d;
    logic        unstable_q, unstable_d;
    logic        err_q, err_d;
    logic        deliver, fsm_err;
    logic        strobe_s;
    logic [2:0]  data_s;

    assign strobe_s = sync_q[3];
    assign data_s   = sync_q[2:0];

    always_comb begin
        // NOTE: every signal written here gets a default first; any path that
        // left one unassigned would infer a latch.
        meta_d     = {controlIn, in2, in1, in0};
        sync_d     = meta_q;
        state_d    = state_q;
        cnt_d      = cnt_q;
        shadow_d   = shadow_q;
        unstable_d = unstable_q;
        deliver    = 1'b0;
        fsm_err    = 1'b0;
        // The counter saturates so that a strobe stuck high forever never wraps.
        cnt_inc    = (cnt_q == '1) ? cnt_q : cnt_q + 32'd1;

        unique case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (strobe_s) begin
                    state_d    = HIGH;
                    cnt_d      = 32'd1;
                    shadow_d   = data_s;
                    unstable_d = 1'b0;
                end
            end
            HIGH: begin
                if (strobe_s) begin
                    cnt_d = cnt_inc;
                    if (data_s != shadow_q) unstable_d = 1'b1;
                    if (cnt_inc >= MAX_PULSE_C) begin
                        fsm_err = 1'b1;
                        state_d = STUCK;
                    end
                end else if (cnt_q < MIN_PULSE_C) begin
                    // A glitch returns to IDLE with no gap requirement and no err.
                    state_d = IDLE;
                    cnt_d   = '0;
                end else begin
                    // This falling cycle is already the first low cycle of the gap.
                    state_d = GAP;
                    cnt_d   = 32'd1;
                    if (unstable_q || shadow_q == 3'd7) fsm_err = 1'b1;
                    else                                deliver = 1'b1;
                end
            end
            STUCK: begin
                if (strobe_s) begin
                    cnt_d = cnt_inc;
                end else begin
                    state_d = GAP;
                    cnt_d   = 32'd1;
                end
            end
            GAP: begin
                if (strobe_s) begin
                    // An early pulse is ignored, and the gap must then start over.
                    cnt_d = '0;
                end else if (cnt_inc >= MIN_GAP_C) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge hwclk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q     <= '0;
            sync_q     <= '0;
            state_q    <= IDLE;
            cnt_q      <= '0;
            shadow_q   <= '0;
            unstable_q <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments let every flop sample the
            // pre-edge values. Blocking ones would collapse the synchronizer
            // chain into a single stage.
            meta_q     <= meta_d;
            sync_q     <= sync_d;
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            shadow_q   <= shadow_d;
            unstable_q <= unstable_d;
            err_q      <= err_d;
        end
    end

    assign busy = (state_q != IDLE);
    assign err  = err_q;

`ifdef RX_FIFO_EN
    logic [2:0] mem_q [4];
    logic [2:0] mem_d [4];
    logic [1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [2:0] count_q, count_d;
    logic       push, pop;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        pop      = (count_q != 3'd0) && ready;
        // A pop in the same cycle frees a slot, so a full FIFO still accepts the digit.
        push     = deliver && ((count_q != 3'd4) || pop);
        err_d    = fsm_err || (deliver && !push);
        if (push) begin
            mem_d[wr_ptr_q] = shadow_q;
            wr_ptr_d        = wr_ptr_q + 2'd1;
        end
        if (pop) rd_ptr_d = rd_ptr_q + 2'd1;
        count_d = count_q + {2'b00, push} - {2'b00, pop};
    end

    always_ff @(posedge hwclk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // NOTE: the storage has no reset. Clearing the pointers empties the
    // FIFO, and num is forced to 0 whenever the FIFO is empty.
    always_ff @(posedge hwclk) begin
        mem_q <= mem_d;
    end

    assign valid = (count_q != 3'd0);
    assign num   = valid ? mem_q[rd_ptr_q] : 3'd0;
`else
    logic [2:0] num_q, num_d;
    logic       valid_q, valid_d;
    logic       ready_unused;

    assign ready_unused = ready;

    always_comb begin
        num_d   = deliver ? shadow_q : num_q;
        valid_d = deliver;
        err_d   = fsm_err;
    end

    always_ff @(posedge hwclk or negedge rst_n) begin
        if (!rst_n) begin
            num_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            num_q   <= num_d;
            valid_q <= valid_d;
        end
    end

    assign valid = valid_q;
    assign num   = num_q;
`endif

endmodule

// File: tb/tb_digit_receiver.sv
// tb_digit_receiver
//   Self-checking bench for digit_receiver, built with HOLD_TIME = 16
//   (MIN_PULSE 8, MAX_PULSE 32, MIN_GAP 8).
//
//   A pulse-level reference model predicts num/valid/err/busy every cycle. It
//   works from the raw inputs seen two edges earlier, tracking run lengths of
//   high and low strobe samples. A compare process checks the DUT against it
//   on every falling clock edge. Directed scenarios also check literal
//   expectations: pulse counts, digits, asynchronous reset values and FIFO
//   order. A randomized phase follows the directed scenarios.
//
//   The FIFO scenario is compiled in only when RX_FIFO_EN is defined.
module tb_digit_receiver;

    localparam int HT   = 16;
    localparam int MINP = 8;
    localparam int MAXP = 32;
    localparam int MING = 8;

    logic       hwclk = 1'b0;
    logic       rst_n = 1'b0;
    logic       in0 = 1'b0, in1 = 1'b0, in2 = 1'b0, controlIn = 1'b0, ready = 1'b1;
    logic [2:0] num;
    logic       valid, err, busy;

    digit_receiver #(
        .HOLD_TIME(HT), .MIN_PULSE(MINP), .MAX_PULSE(MAXP), .MIN_GAP(MING)
    ) dut (
        .hwclk(hwclk), .rst_n(rst_n), .in0(in0), .in1(in1), .in2(in2),
        .controlIn(controlIn), .ready(ready),
        .num(num), .valid(valid), .err(err), .busy(busy)
    );

    always #5 hwclk = ~hwclk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    bit [3:0] h0, h1;          // raw {strobe, data} sampled one and two edges ago
    bit       in_pulse, stuck, armed;
    int       len, low_run;
    bit [2:0] shadow;
    bit       bad;
    bit       s, deliver, reject, pop;
    bit [2:0] d;
    int       q[$];
    bit       exp_valid, exp_err, exp_busy;
    bit [2:0] exp_num;

    always @(posedge hwclk or negedge rst_n) begin
        if (!rst_n) begin
            h0 = '0; h1 = '0;
            in_pulse = 0; stuck = 0; armed = 1;
            len = 0; low_run = 0; shadow = 0; bad = 0;
            q.delete();
            exp_valid = 0; exp_err = 0; exp_busy = 0; exp_num = 0;
        end else begin
            s  = h1[3];
            d  = h1[2:0];
            h1 = h0;
            h0 = {controlIn, in2, in1, in0};
            deliver = 0;
            reject  = 0;
            if (in_pulse) begin
                if (s) begin
                    len++;
                    if (d != shadow) bad = 1;
                    if (len >= MAXP) begin
                        reject = 1; in_pulse = 0; stuck = 1;
                    end
                end else begin
                    in_pulse = 0;
                    if (len < MINP) armed = 1;
                    else begin
                        low_run = 1;
                        if (bad || shadow == 3'd7) reject = 1;
                        else deliver = 1;
                    end
                end
            end else if (stuck) begin
                if (!s) begin stuck = 0; low_run = 1; end
            end else if (!armed) begin
                low_run = s ? 0 : low_run + 1;
                if (low_run >= MING) armed = 1;
            end else if (s) begin
                in_pulse = 1; armed = 0; len = 1; shadow = d; bad = 0;
            end
`ifdef RX_FIFO_EN
            pop = (q.size() > 0) && ready;
            if (pop) void'(q.pop_front());
            if (deliver) begin
                if (q.size() < 4) q.push_back(int'(shadow));
                else reject = 1;
            end
            exp_valid = (q.size() > 0);
            exp_num   = exp_valid ? 3'(q[0]) : 3'd0;
`else
            pop       = 0;
            exp_valid = deliver;
            if (deliver) exp_num = shadow;
`endif
            exp_err  = reject;
            exp_busy = in_pulse || stuck || !armed;
        end
    end

    // ---------------- compare process + event counters ----------------
    int       valid_cnt = 0;
    int       err_cnt   = 0;
    bit [2:0] last_num  = 0;

    always @(negedge hwclk) begin
        check("valid", int'(valid), int'(exp_valid));
        check("num",   int'(num),   int'(exp_num));
        check("err",   int'(err),   int'(exp_err));
        check("busy",  int'(busy),  int'(exp_busy));
        if (valid) begin valid_cnt++; last_num = num; end
        if (err) err_cnt++;
    end

    // ---------------- stimulus helpers ----------------
    bit rand_ready = 0;

    task automatic drive_ready();
        if (rand_ready) ready = 1'($urandom_range(0, 1));
    endtask

    task automatic send(input logic [2:0] d1, input logic [2:0] d2, input int change_at,
                        input int high, input int low);
        for (int i = 0; i < high; i++) begin
            @(negedge hwclk);
            {in2, in1, in0} = (i < change_at) ? d1 : d2;
            controlIn = 1'b1;
            drive_ready();
        end
        for (int i = 0; i < low; i++) begin
            @(negedge hwclk);
            {in2, in1, in0} = 3'($urandom_range(0, 7));
            controlIn = 1'b0;
            drive_ready();
        end
    endtask

    task automatic clear_counts();
        #1;
        valid_cnt = 0;
        err_cnt   = 0;
    endtask

    initial begin
        // Reset state.
        repeat (3) @(negedge hwclk);
        #1;
        check("reset num",   int'(num),   0);
        check("reset valid", int'(valid), 0);
        check("reset err",   int'(err),   0);
        check("reset busy",  int'(busy),  0);
        @(negedge hwclk);
        rst_n = 1'b1;
        send(3'd0, 3'd0, 1000, 0, 10);

        // 1. Clean pulse delivers exactly one digit.
        clear_counts();
        send(3'd5, 3'd5, 1000, HT, HT);
        #1;
        check("t1 valid count", valid_cnt, 1);
        check("t1 num", int'(last_num), 5);
        check("t1 err count", err_cnt, 0);
        check("t1 busy idle", int'(busy), 0);

        // 2. Short pulse is a glitch.
        clear_counts();
        send(3'd2, 3'd2, 1000, 3, HT);
        #1;
        check("t2 valid count", valid_cnt, 0);
        check("t2 err count", err_cnt, 0);
        check("t2 busy idle", int'(busy), 0);

        // 3. Data unstable, then a clean pulse.
        clear_counts();
        send(3'd3, 3'd4, 10, HT, HT);
        #1;
        check("t3 err count", err_cnt, 1);
        check("t3 valid count", valid_cnt, 0);
        clear_counts();
        send(3'd1, 3'd1, 1000, HT, HT);
        #1;
        check("t3 clean valid count", valid_cnt, 1);
        check("t3 clean num", int'(last_num), 1);

        // 4. Code 7, then a stuck strobe, then a clean pulse.
        clear_counts();
        send(3'd7, 3'd7, 1000, HT, HT);
        #1;
        check("t4 code7 err", err_cnt, 1);
        check("t4 code7 valid", valid_cnt, 0);
        clear_counts();
        send(3'd6, 3'd6, 1000, 40, HT);
        #1;
        check("t4 stuck err", err_cnt, 1);
        check("t4 stuck valid", valid_cnt, 0);
        clear_counts();
        send(3'd2, 3'd2, 1000, HT, HT);
        #1;
        check("t4 after valid", valid_cnt, 1);
        check("t4 after num", int'(last_num), 2);

        // 5. A pulse inside the gap is ignored; the next pulse after the gap is accepted.
        clear_counts();
        send(3'd4, 3'd4, 1000, HT, 4);
        send(3'd6, 3'd6, 1000, HT, HT);
        #1;
        check("t5 gap valid count", valid_cnt, 1);
        check("t5 gap num", int'(last_num), 4);
        check("t5 gap err", err_cnt, 0);
        clear_counts();
        send(3'd3, 3'd3, 1000, HT, HT);
        #1;
        check("t5 accepted num", int'(last_num), 3);

        // Asynchronous reset in the middle of a pulse.
        @(negedge hwclk);
        {in2, in1, in0} = 3'd5;
        controlIn = 1'b1;
        repeat (10) @(negedge hwclk);
        #1;
        check("t5 busy mid pulse", int'(busy), 1);
        #1 rst_n = 1'b0;
        #1;
        check("t5 async num",   int'(num),   0);
        check("t5 async valid", int'(valid), 0);
        check("t5 async err",   int'(err),   0);
        check("t5 async busy",  int'(busy),  0);
        @(negedge hwclk);
        rst_n = 1'b1;
        send(3'd5, 3'd5, 1000, 3, HT);

        // Randomized pulses, with random ready throttling in the FIFO build.
        rand_ready = 1;
        for (int n = 0; n < 150; n++) begin
            int hi, lo, chg;
            hi  = $urandom_range(1, 40);
            lo  = $urandom_range(1, 20);
            chg = ($urandom_range(0, 3) == 0 && hi > 1) ? $urandom_range(1, hi - 1) : 1000;
            send(3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)), chg, hi, lo);
        end
        rand_ready = 0;
        ready = 1'b1;
        send(3'd0, 3'd0, 1000, 0, 40);

`ifdef RX_FIFO_EN
        // 6. FIFO fills, overflows on the fifth digit, then drains in order.
        ready = 1'b0;
        clear_counts();
        for (int i = 0; i < 5; i++) send(3'(i), 3'(i), 1000, HT, HT);
        #1;
        check("t6 valid held", int'(valid), 1);
        check("t6 overflow err", err_cnt, 1);
        @(negedge hwclk);
        ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            check("t6 drain valid", int'(valid), 1);
            check("t6 drain num", int'(num), i);
            @(negedge hwclk);
        end
        check("t6 empty", int'(valid), 0);
`endif

        repeat (4) @(negedge hwclk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
